// File: rtl/sync_debounce_pkg.sv
// Shared defaults and helpers for the synchroniser/debounce bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_debounce_pkg;

  localparam int   DEF_CH          = 2;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_DB_CYCLES   = 4;
  localparam logic DEF_RESET_VAL   = 1'b0;

  // Debounce counter width: enough to hold DB_CYCLES, never narrower than one bit.
  function automatic int cnt_width(input int db_cycles);
    int w;
    w = $clog2(db_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// Single channel: metastability synchroniser, debounce filter, registered rise/fall pulses.
// Latency: din -> sync_out SYNC_STAGES edges; din -> dout SYNC_STAGES + DB_CYCLES edges with en held high.
// Backpressure: none; en only gates the debounce counter, the sync chain always shifts.
module sync_debounce_ch
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   DB_CYCLES   = DEF_DB_CYCLES,
  parameter logic RESET_VAL   = DEF_RESET_VAL
) (
  input  logic clk,
  input  logic arst,
  input  logic en,
  input  logic din,
  output logic sync_out,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic edge_nxt
);

  localparam int             CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   dout_d;
  logic                   rise_d;
  logic                   fall_d;

  // Shift the raw input through the synchroniser chain every edge, independent of en.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce decision: count enabled cycles of disagreement, commit on the terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en) begin
      if (sync_out == dout) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        dout_d = sync_out;
        cnt_d  = '0;
        rise_d = sync_out;
        fall_d = ~sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Early strobe so the bank can register its summary flag in the same cycle as rise/fall.
  assign edge_nxt = rise_d | fall_d;

  // Register the filtered level, the counter and the edge pulses together.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
      dout  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dout  <= dout_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of CH independent synchronise/debounce/edge-detect channels plus a registered "any edge" flag.
// Latency: din -> dout SYNC_STAGES + DB_CYCLES edges; changed aligns with rise/fall.
// Backpressure: none; en pauses debouncing on all channels, synchronisers keep running.
module sync_debounce_bank
  import sync_debounce_pkg::*;
#(
  parameter int   CH          = DEF_CH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   DB_CYCLES   = DEF_DB_CYCLES,
  parameter logic RESET_VAL   = DEF_RESET_VAL
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          en,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] sync_out,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          changed
);

  typedef logic [CH-1:0] ch_vec_t;

  ch_vec_t edge_nxt;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    sync_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RESET_VAL   (RESET_VAL)
    ) u_ch (
      .clk      (clk),
      .arst     (arst),
      .en       (en),
      .din      (din[i]),
      .sync_out (sync_out[i]),
      .dout     (dout[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .edge_nxt (edge_nxt[i])
    );
  end

  // Register the OR of next-cycle edge strobes so changed lands with rise/fall.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      changed <= 1'b0;
    end else begin
      changed <= |edge_nxt;
    end
  end

endmodule
